// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that hands queued bytes to a UART transmitter one frame at a time.
// Define UART_TX_BUF_OVF_EN to add the sticky overflow flag and its ovf_clr input.
module uart_tx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_enable,
`ifdef UART_TX_BUF_OVF_EN
    output logic                   overflow,
    input  logic                   ovf_clr,
`endif
    input  logic                   tx_sending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_enable_q, tx_enable_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            sync_sending_s;

    assign full_s         = (count_q == FULL_CNT);
    assign empty_s        = (count_q == {CW{1'b0}});
    assign push_s         = wr_en && !full_s;
    assign sync_sending_s = sync2_q;
    assign sync1_d        = tx_sending;
    assign sync2_d        = sync1_q;

    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE);
    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;

    // Write pointer and occupancy; a write seen while full never touches storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer: pop one byte, hold the request until the transmitter starts, then wait for it to finish.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = tx_enable_q;
        pop_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    tx_data_d   = mem_q[rd_ptr_q];
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    tx_enable_d = 1'b1;
                    state_d     = S_WAIT_START;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_START: begin
                if (sync_sending_s) begin
                    tx_enable_d = 1'b0;
                    state_d     = S_WAIT_DONE;
                end else begin
                    state_d     = S_WAIT_START;
                end
            end
            S_WAIT_DONE: begin
                if (!sync_sending_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                tx_enable_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Control registers, including the two-flop synchronizer on tx_sending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            tx_data_q   <= 8'h00;
            tx_enable_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    // Byte storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TX_BUF_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a new drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: scoreboard of written bytes against bytes
// presented to an emulated transmitter, plus timing, boundary and reset scenarios.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_sending;
`ifdef UART_TX_BUF_OVF_EN
    logic       overflow;
    logic       ovf_clr;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
`ifdef UART_TX_BUF_OVF_EN
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
`endif
        .tx_sending (tx_sending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Emulated transmitter: take one request, acknowledge it, finish the frame.
    task automatic drain_one(output logic [7:0] b, output bit timed_out);
        timed_out = 1'b0;
        b = 8'h00;
        for (int k = 0; k < 60; k++) begin
            if (tx_enable === 1'b1) break;
            step();
        end
        if (tx_enable !== 1'b1) begin
            timed_out = 1'b1;
        end else begin
            b = tx_data;
            tx_sending = 1'b1;
            for (int k = 0; k < 20; k++) begin
                if (tx_enable === 1'b0) break;
                step();
            end
            if (tx_enable !== 1'b0) timed_out = 1'b1;
            repeat (3) step();
            tx_sending = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (busy === 1'b0) break;
                step();
            end
            if (busy !== 1'b0) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (tx_enable !== 1'b0) begin n_errors++; $display("FAIL reset_tx_enable: got %b expected 0", tx_enable); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
`ifdef UART_TX_BUF_OVF_EN
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
    endtask

    task automatic test_single_byte();
        logic [7:0] e;
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_count_n: got %0d expected 1", count); end
        n_checks++; if (tx_enable !== 1'b0) begin n_errors++; $display("FAIL single_early_en: got %b expected 0", tx_enable); end
        step();
        e = exp_q.pop_front();
        n_checks++; if (tx_enable !== 1'b1) begin n_errors++; $display("FAIL single_en: got %b expected 1", tx_enable); end
        n_checks++; if (tx_data !== e) begin n_errors++; $display("FAIL single_data: got %h expected %h", tx_data, e); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL single_count_n1: got %0d expected 0", count); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        tx_sending = 1'b1;
        step(); step();
        n_checks++; if (tx_enable !== 1'b1) begin n_errors++; $display("FAIL single_en_hold: got %b expected 1", tx_enable); end
        step();
        n_checks++; if (tx_enable !== 1'b0) begin n_errors++; $display("FAIL single_en_fall: got %b expected 0", tx_enable); end
        tx_sending = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_done: got %b expected 0", busy); end
    endtask

    task automatic test_burst();
        logic [7:0] b, e;
        bit to;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1); exp_q.push_back(8'(i + 1));
            step();
        end
        n_checks++; if (count !== 5'd15) begin n_errors++; $display("FAIL burst_count15: got %0d expected 15", count); end
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL burst_not_full: got %b expected 0", full); end
        wr_data = 8'h11; exp_q.push_back(8'h11);
        step();
        n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL burst_full: got %b expected 1", full); end
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL burst_drop_count: got %0d expected 16", count); end
        drain_one(b, to);
        e = exp_q.pop_front();
        n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL burst_first: got %h expected %h timeout=%0d", b, e, to); end
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd15) begin n_errors++; $display("FAIL burst_full_pop_drop: got %0d expected 15", count); end
        while (exp_q.size() > 0) begin
            drain_one(b, to);
            e = exp_q.pop_front();
            n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL burst_order: got %h expected %h timeout=%0d", b, e, to); end
        end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL burst_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] b, e;
        bit to;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 10; i++) begin
                wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255)); exp_q.push_back(wr_data);
                step();
            end
            wr_en = 1'b0;
            for (int i = 0; i < 10; i++) begin
                drain_one(b, to);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL wrap_order: got %h expected %h timeout=%0d", b, e, to); end
            end
        end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] b, e;
        bit to;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i); exp_q.push_back(wr_data);
            step();
        end
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd5) begin n_errors++; $display("FAIL simul_pre_count: got %0d expected 5", count); end
        drain_one(b, to);
        e = exp_q.pop_front();
        n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL simul_first: got %h expected %h timeout=%0d", b, e, to); end
        n_checks++; if (busy !== 1'b0 || count !== 5'd5) begin n_errors++; $display("FAIL simul_idle5: got busy=%b count=%0d expected busy=0 count=5", busy, count); end
        wr_en = 1'b1; wr_data = 8'h7A; exp_q.push_back(8'h7A);
        step();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd5) begin n_errors++; $display("FAIL simul_count: got %0d expected 5", count); end
        n_checks++; if (tx_enable !== 1'b1 || tx_data !== exp_q[0]) begin n_errors++; $display("FAIL simul_oldest: got en=%b data=%h expected en=1 data=%h", tx_enable, tx_data, exp_q[0]); end
        while (exp_q.size() > 0) begin
            drain_one(b, to);
            e = exp_q.pop_front();
            n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL simul_order: got %h expected %h timeout=%0d", b, e, to); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b, e;
        bit to, seen_en;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h90 + i);
            step();
        end
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd3 || tx_enable !== 1'b1 || tx_data !== 8'h90) begin n_errors++; $display("FAIL rmid_pre: got count=%0d en=%b data=%h expected 3 1 90", count, tx_enable, tx_data); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (tx_enable !== 1'b0) begin n_errors++; $display("FAIL rmid_en: got %b expected 0", tx_enable); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL rmid_empty: got %b expected 1", empty); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        seen_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx_enable !== 1'b0) seen_en = 1'b1;
        end
        n_checks++; if (seen_en) begin n_errors++; $display("FAIL rmid_quiet: got tx_enable=1 expected 0"); end
        wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
        step();
        wr_en = 1'b0;
        drain_one(b, to);
        e = exp_q.pop_front();
        n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL rmid_recover: got %h expected %h timeout=%0d", b, e, to); end
    endtask

`ifdef UART_TX_BUF_OVF_EN
    task automatic test_overflow();
        logic [7:0] b, e;
        bit to, lost;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i); exp_q.push_back(wr_data);
            step();
        end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        lost = 1'b0;
        repeat (100) begin
            step();
            if (overflow !== 1'b1) lost = 1'b1;
        end
        n_checks++; if (lost) begin n_errors++; $display("FAIL ovf_sticky: got 0 expected 1"); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        step();
        ovf_clr = 1'b0; wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        while (exp_q.size() > 0) begin
            drain_one(b, to);
            e = exp_q.pop_front();
            n_checks++; if (to || b !== e) begin n_errors++; $display("FAIL ovf_order: got %h expected %h timeout=%0d", b, e, to); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_sending = 1'b0;
`ifdef UART_TX_BUF_OVF_EN
        ovf_clr = 1'b0;
`endif
        test_reset();
        test_single_byte();
        test_burst();
        test_wrap();
        test_simul_push_pop();
        test_reset_mid_frame();
`ifdef UART_TX_BUF_OVF_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
